// File: rtl/regfile_mp.sv
// Multi-port integer register file with write bypass and a pending-write (busy) scoreboard.
// Optional macro RF_RDREG_EN registers the read outputs for one cycle of read latency.
module regfile_mp #(
  parameter int                DWIDTH  = 32,
  parameter int                NREGS   = 32,
  parameter int                AWIDTH  = $clog2(NREGS),
  parameter int                NRD     = 2,
  parameter int                NWR     = 1,
  parameter int                SP_IDX  = 2,
  parameter logic [DWIDTH-1:0] SP_INIT = 32'h0110_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NRD*AWIDTH-1:0]   rs_addr_i,
  output logic [NRD*DWIDTH-1:0]   rs_data_o,
  output logic [NRD-1:0]          rs_busy_o,
  input  logic [NWR-1:0]          wr_en_i,
  input  logic [NWR*AWIDTH-1:0]   wr_addr_i,
  input  logic [NWR*DWIDTH-1:0]   wr_data_i,
  input  logic                    busy_set_i,
  input  logic [AWIDTH-1:0]       busy_addr_i,
  input  logic                    flush_i
);

  if (NREGS < 2 || NREGS > 64 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
    $error("regfile_mp: NREGS must be a power of two in 2..64");
  end
  if (AWIDTH != $clog2(NREGS)) begin : g_bad_awidth
    $error("regfile_mp: AWIDTH must equal clog2(NREGS)");
  end
  if (NRD < 1 || NRD > 4) begin : g_bad_nrd
    $error("regfile_mp: NRD must be in 1..4");
  end
  if (NWR < 1 || NWR > 2) begin : g_bad_nwr
    $error("regfile_mp: NWR must be in 1..2");
  end
  if (SP_IDX < 1 || SP_IDX >= NREGS) begin : g_bad_sp
    $error("regfile_mp: SP_IDX must be a nonzero register index");
  end

  logic [DWIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;

  logic [AWIDTH-1:0] wa [NWR];
  logic [DWIDTH-1:0] wd [NWR];
  logic [AWIDTH-1:0] ra [NRD];
  logic [DWIDTH-1:0] rd_c [NRD];
  logic [NRD-1:0]    rb_c;
  logic [NRD*DWIDTH-1:0] rd_flat;

  always_comb begin
    for (int w = 0; w < NWR; w++) begin
      wa[w] = wr_addr_i[w*AWIDTH +: AWIDTH];
      wd[w] = wr_data_i[w*DWIDTH +: DWIDTH];
    end
  end

  // Ascending port order: a later non-blocking write wins, so port NWR-1 has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en_i[w] && wa[w] != '0) begin
          regs[wa[w]] <= wd[w];
        end
      end
    end
  end

  // Flush beats everything; a new producer (set) supersedes a completing one (clear).
  always_comb begin
    busy_nxt = busy;
    if (flush_i) begin
      busy_nxt = '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en_i[w]) begin
          busy_nxt[wa[w]] = 1'b0;
        end
      end
      if (busy_set_i) begin
        busy_nxt[busy_addr_i] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Read with bypass: a register being written back this cycle shows the new data and is not busy.
  always_comb begin
    rb_c = '0;
    for (int k = 0; k < NRD; k++) begin
      ra[k]   = rs_addr_i[k*AWIDTH +: AWIDTH];
      rd_c[k] = regs[ra[k]];
      rb_c[k] = busy[ra[k]];
      for (int w = 0; w < NWR; w++) begin
        if (wr_en_i[w] && wa[w] == ra[k]) begin
          rd_c[k] = wd[w];
          rb_c[k] = 1'b0;
        end
      end
      if (ra[k] == '0) begin
        rd_c[k] = '0;
        rb_c[k] = 1'b0;
      end
    end
  end

  always_comb begin
    rd_flat = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_flat[k*DWIDTH +: DWIDTH] = rd_c[k];
    end
  end

`ifdef RF_RDREG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_data_o <= '0;
      rs_busy_o <= '0;
    end else begin
      rs_data_o <= rd_flat;
      rs_busy_o <= rb_c;
    end
  end
`else
  assign rs_data_o = rd_flat;
  assign rs_busy_o = rb_c;
`endif

endmodule
